// File: rtl/mem_miss_arbiter.sv
// rtl/mem_miss_arbiter.sv - shares one external memory port between I-cache and D-cache line transfers
//
// Purpose:
//   Arbitrates I-cache refills against D-cache refills/writebacks, runs one
//   line transfer at a time on the shared memory port, steers response beats
//   back to the owner and raises the pipeline memory-wait stall.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   i_req, i_addr         I-cache miss request (level) and line address
//   d_req, d_addr, d_we   D-cache request (level), line address, 1=writeback
//   mem_req_*             request channel to memory (valid/ready, addr, we)
//   mem_rsp_*             response beats from memory (valid, last, data)
//   i_rsp_valid           response beat belongs to the I-cache
//   d_rsp_valid           response beat belongs to the D-cache
//   rsp_last, rsp_data    final-beat flag and beat data for the owner
//   stall_miss            pipeline memory-wait stall
//   proto_err             sticky last/beat-count mismatch flag

module mem_miss_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int BEATS      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    input  logic              mem_rsp_valid,
    input  logic              mem_rsp_last,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              i_rsp_valid,
    output logic              d_rsp_valid,
    output logic              rsp_last,
    output logic [DATA_W-1:0] rsp_data,
    output logic              stall_miss,
    output logic              proto_err
);

    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [BCNT_W-1:0] LAST_IDX   = BCNT_W'(BEATS - 1);
    localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;        // 0 = I-cache, 1 = D-cache
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [BCNT_W-1:0]   r_beat_cnt;
    logic [SCNT_W-1:0]   r_starve_cnt;
    logic                r_proto_err;

    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_beat;
    logic                w_bad_count;

    // D normally wins; once I has watched STARVE_MAX consecutive D grants it
    // takes the next slot.
    assign w_grant_d = d_req & ~(i_req & (r_starve_cnt == STARVE_LIM));
    assign w_grant_i = i_req & ~w_grant_d;

    // Beats outside RESP (stray or left over from an abandoned transfer) are
    // dropped silently.
    assign w_beat = (r_state == ST_RESP) & mem_rsp_valid;

    // A writeback is acknowledged by a single last beat, so only refills are
    // held to the line length.
    assign w_bad_count = ~r_we & ((mem_rsp_last & (r_beat_cnt != LAST_IDX)) |
                                  (~mem_rsp_last & (r_beat_cnt == LAST_IDX)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_beat_cnt   <= '0;
            r_starve_cnt <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_owner <= 1'b1;
                        r_addr  <= d_addr;
                        r_we    <= d_we;
                        if (i_req && (r_starve_cnt != STARVE_LIM)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (w_grant_i) begin
                        r_owner      <= 1'b0;
                        r_addr       <= i_addr;
                        r_we         <= 1'b0;
                        r_starve_cnt <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_beat_cnt <= '0;
                    end
                end
                ST_RESP: begin
                    if (mem_rsp_valid) begin
                        r_beat_cnt <= (r_beat_cnt == LAST_IDX) ? '0 : r_beat_cnt + 1'b1;
                        if (w_bad_count) begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_we    = 1'b0;
        i_rsp_valid   = 1'b0;
        d_rsp_valid   = 1'b0;
        rsp_last      = 1'b0;
        rsp_data      = '0;
        stall_miss    = 1'b0;
        proto_err     = 1'b0;

        case (r_state)
            ST_IDLE: if (i_req || d_req)                 w_state_nxt = ST_REQ;
            ST_REQ:  if (mem_req_ready)                  w_state_nxt = ST_RESP;
            ST_RESP: if (mem_rsp_valid && mem_rsp_last)  w_state_nxt = ST_DONE;
            default:                                     w_state_nxt = ST_IDLE;
        endcase

        // Outputs are forced low while reset is held, even though the state
        // registers only clear on the next edge.
        if (reset_n) begin
            mem_req_valid = (r_state == ST_REQ);
            mem_req_addr  = r_addr;
            mem_req_we    = r_we;
            i_rsp_valid   = w_beat & ~r_owner;
            d_rsp_valid   = w_beat & r_owner;
            rsp_last      = w_beat & mem_rsp_last;
            rsp_data      = mem_rsp_data;
            proto_err     = r_proto_err;
            case (r_state)
                ST_IDLE: stall_miss = i_req | d_req;
                // The served owner has dropped its request here, so only a
                // waiting non-owner keeps the pipeline frozen.
                ST_DONE: stall_miss = r_owner ? i_req : d_req;
                default: stall_miss = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// tb/tb_mem_miss_arbiter.sv - scoreboard bench for mem_miss_arbiter with randomized traffic
module tb_mem_miss_arbiter;

    localparam int BEATS      = 8;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_we;
    logic [63:0] i_addr, d_addr;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid, mem_rsp_last;
    logic [63:0] mem_rsp_data;
    logic        i_rsp_valid, d_rsp_valid, rsp_last, stall_miss, proto_err;
    logic [63:0] rsp_data;

    always #5 clk = ~clk;

    mem_miss_arbiter #(.ADDR_W(64), .DATA_W(64), .BEATS(BEATS), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_last(mem_rsp_last), .mem_rsp_data(mem_rsp_data),
        .i_rsp_valid(i_rsp_valid), .d_rsp_valid(d_rsp_valid),
        .rsp_last(rsp_last), .rsp_data(rsp_data),
        .stall_miss(stall_miss), .proto_err(proto_err)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic        owner;
        logic [7:0]  nbeats;
        logic [7:0]  cut;
    } job_t;

    typedef struct packed {
        logic        owner;
        logic [63:0] data;
        logic        last;
    } beat_t;

    job_t  plan_i[$], plan_d[$], exp_grants[$], mem_jobs[$];
    beat_t exp_beats[$];

    int checks = 0, failures = 0;
    int m_starve = 0;
    bit m_proto = 1'b0;
    int bp_force = 0;
    bit mon_en = 1'b0;
    int beats_seen = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    function automatic job_t mk(input logic owner, input logic [63:0] addr, input logic we, input int nb);
        job_t j;
        j.addr   = addr;
        j.we     = we;
        j.owner  = owner;
        j.nbeats = we ? 8'd1 : 8'(nb);
        j.cut    = 8'd0;
        return j;
    endfunction

    // Reference model: both requesters hold their jobs until served and
    // re-request on the first IDLE after their DONE, so the grant order follows
    // from the two job lists and the starvation count alone.
    task automatic plan_batch();
        int a = 0;
        int b = 0;
        job_t j;
        while (a < plan_i.size() || b < plan_d.size()) begin
            bit pi;
            bit pd;
            pi = (a < plan_i.size());
            pd = (b < plan_d.size());
            if (pd && !(pi && m_starve == STARVE_MAX)) begin
                j = plan_d[b];
                b++;
                if (pi && m_starve < STARVE_MAX) m_starve++;
            end else begin
                j = plan_i[a];
                a++;
                m_starve = 0;
            end
            if (!j.we && int'(j.nbeats) != BEATS) m_proto = 1'b1;
            exp_grants.push_back(j);
        end
    endtask

    task automatic wait_last(input logic owner);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((owner ? d_rsp_valid : i_rsp_valid) && rsp_last) break;
            n++;
            if (n > 1000) begin
                fail_now(owner ? "d_transfer_timeout" : "i_transfer_timeout");
                break;
            end
        end
    endtask

    task automatic run_i();
        job_t j;
        while (plan_i.size() > 0) begin
            j = plan_i.pop_front();
            i_addr = j.addr;
            i_req  = 1'b1;
            wait_last(1'b0);
            @(posedge clk); #1;
            i_req  = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_d();
        job_t j;
        while (plan_d.size() > 0) begin
            j = plan_d.pop_front();
            d_addr = j.addr;
            d_we   = j.we;
            d_req  = 1'b1;
            wait_last(1'b1);
            @(posedge clk); #1;
            d_req  = 1'b0;
            d_we   = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
    endtask

    task automatic run_batch(input string tag, input bit lat_chk, input logic [63:0] lat_addr);
        plan_batch();
        fork
            run_i();
            run_d();
            if (lat_chk) begin
                @(negedge clk);
                chk({tag, "_req_cycle"}, 160'({mem_req_valid, stall_miss}), 160'(2'b01));
                @(negedge clk);
                chk({tag, "_grant_latency"}, 160'({mem_req_valid, mem_req_addr}), 160'({1'b1, lat_addr}));
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_proto_err"}, 160'(proto_err), 160'(m_proto));
        chk({tag, "_grants_pending"}, 160'(exp_grants.size()), 160'(0));
        chk({tag, "_beats_pending"}, 160'(exp_beats.size()), 160'(0));
    endtask

    function automatic logic [63:0] rnd_addr(input logic [31:0] region);
        logic [31:0] lo;
        lo = $urandom;
        return {region, lo[31:6], 6'h0};
    endfunction

    task automatic rand_batch(input string tag);
        int ni, nd;
        ni = $urandom_range(3);
        nd = $urandom_range(5);
        for (int k = 0; k < ni; k++) plan_i.push_back(mk(1'b0, rnd_addr(32'h1), 1'b0, BEATS));
        for (int k = 0; k < nd; k++) plan_d.push_back(mk(1'b1, rnd_addr(32'h2), 1'($urandom_range(1)), BEATS));
        run_batch(tag, 1'b0, 64'h0);
    endtask

    // Memory: accepts requests with random ready, returns beats with random
    // gaps, and emits stray beats whenever no transfer is outstanding.
    initial begin : mem_model
        job_t  cur;
        beat_t bt;
        bit    busy;
        int    idx;
        busy = 1'b0;
        idx  = 0;
        cur  = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_last  = 1'b0;
            mem_rsp_data  = {$urandom, $urandom};
            if (!reset_n) begin
                busy = 1'b0;
                mem_jobs.delete();
            end
            if (bp_force > 0) begin
                mem_req_ready = 1'b0;
                bp_force--;
            end else begin
                mem_req_ready = ($urandom_range(3) != 0);
            end
            if (!busy && mem_jobs.size() > 0) begin
                cur  = mem_jobs.pop_front();
                busy = 1'b1;
                idx  = 0;
            end
            if (busy) begin
                if ((cur.cut == 8'd0 || idx < int'(cur.cut)) && $urandom_range(3) != 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_last  = (idx == int'(cur.nbeats) - 1);
                    bt.owner = cur.owner;
                    bt.data  = mem_rsp_data;
                    bt.last  = mem_rsp_last;
                    exp_beats.push_back(bt);
                    idx++;
                    if (mem_rsp_last) busy = 1'b0;
                end
            end else if ($urandom_range(3) == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_last  = 1'($urandom_range(1));
            end
        end
    end

    initial begin : monitor
        logic        prev_wait;
        logic [63:0] prev_addr;
        logic        prev_we;
        beat_t       b;
        job_t        j;
        prev_wait = 1'b0;
        prev_addr = '0;
        prev_we   = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("reset_outputs_zero",
                    160'({mem_req_valid, mem_req_addr, mem_req_we, i_rsp_valid, d_rsp_valid,
                          rsp_last, rsp_data, stall_miss, proto_err}), 160'(0));
                prev_wait = 1'b0;
            end else if (mon_en) begin
                chk("stall_miss", 160'(stall_miss), 160'(i_req | d_req));
                if (prev_wait)
                    chk("backpressure_hold", 160'({mem_req_valid, mem_req_we, mem_req_addr}),
                        160'({1'b1, prev_we, prev_addr}));
                prev_wait = mem_req_valid && !mem_req_ready;
                prev_addr = mem_req_addr;
                prev_we   = mem_req_we;
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_grants.size() == 0) begin
                        fail_now("unexpected_grant");
                    end else begin
                        j = exp_grants.pop_front();
                        chk("grant_addr_we", 160'({mem_req_we, mem_req_addr}), 160'({j.we, j.addr}));
                        mem_jobs.push_back(j);
                    end
                end
                if (i_rsp_valid || d_rsp_valid) begin
                    beats_seen++;
                    if (exp_beats.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        b = exp_beats.pop_front();
                        chk("beat_route", 160'({i_rsp_valid, d_rsp_valid, rsp_last, rsp_data}),
                            160'({~b.owner, b.owner, b.last, b.data}));
                    end
                end else if (mem_rsp_valid) begin
                    chk("stray_last_gated", 160'(rsp_last), 160'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : main
        int base, n;
        job_t j;
        reset_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0;  d_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        plan_i.push_back(mk(1'b0, 64'h1000, 1'b0, BEATS));
        run_batch("t1_single_i", 1'b1, 64'h1000);

        plan_i.push_back(mk(1'b0, 64'h3000, 1'b0, BEATS));
        plan_d.push_back(mk(1'b1, 64'h2000, 1'b0, BEATS));
        run_batch("t2_simultaneous", 1'b1, 64'h2000);

        plan_i.push_back(mk(1'b0, 64'h4000, 1'b0, BEATS));
        for (int k = 0; k < 6; k++)
            plan_d.push_back(mk(1'b1, 64'h5000 + 64'(k * 64), 1'(k % 2), BEATS));
        run_batch("t3_starvation", 1'b0, 64'h0);

        bp_force = 7;
        plan_d.push_back(mk(1'b1, 64'h9000, 1'b1, BEATS));
        run_batch("t4_backpressure", 1'b1, 64'h9000);

        for (int r = 0; r < 6; r++) rand_batch("rand_a");

        plan_i.push_back(mk(1'b0, 64'hA000, 1'b0, 4));
        plan_d.push_back(mk(1'b1, 64'hB000, 1'b0, BEATS));
        plan_d.push_back(mk(1'b1, 64'hB040, 1'b0, BEATS));
        run_batch("t5_short_line", 1'b0, 64'h0);

        for (int r = 0; r < 3; r++) rand_batch("rand_b");

        j = mk(1'b1, 64'h6000, 1'b0, BEATS);
        j.cut = 8'd2;
        exp_grants.push_back(j);
        d_addr = 64'h6000;
        d_we   = 1'b0;
        d_req  = 1'b1;
        base = beats_seen;
        n = 0;
        while (beats_seen < base + 2 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) fail_now("t6_two_beats_timeout");
        chk("t6_beats_before_reset", 160'(exp_beats.size()), 160'(0));
        reset_n = 1'b0;
        i_req   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        m_starve = 0;
        m_proto  = 1'b0;
        exp_grants.delete();
        exp_beats.delete();
        repeat (3) @(posedge clk);
        #1;
        plan_d.push_back(mk(1'b1, 64'h7000, 1'b0, BEATS));
        run_batch("t6_after_reset", 1'b1, 64'h7000);

        plan_i.push_back(mk(1'b0, 64'h8000, 1'b0, BEATS + 1));
        run_batch("long_line", 1'b0, 64'h0);

        for (int r = 0; r < 3; r++) rand_batch("rand_c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
